pkt_gen: RTL and testbench

PKT_GEN -- requirements
Module: pkt_gen

---
 rtl/pkt_gen_pkg.sv | 20 ++
 rtl/pkt_gen.sv | 114 +++++++++++
 tb/tb_pkt_gen.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_gen_pkg.sv
// Shared definitions for the packet generator: FSM state encoding and the
// 32-bit data pattern word layout.
package pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 16;

  // Packet index in the upper half, beat index in the lower half.
  function automatic logic [WORD_W-1:0] pattern_word(input logic [IDX_W-1:0] pkt_idx,
                                                     input logic [IDX_W-1:0] beat_idx);
    return {pkt_idx, beat_idx};
  endfunction

endpackage

// File: rtl/pkt_gen.sv
// AXI4-Stream packet generator: emits runs of fixed-length packets carrying a
// {packet,beat} counting pattern, with optional idle gaps and graceful abort.
module pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0]     cfg_packets,
  input  logic [15:0]     cfg_beats,
  input  logic [7:0]      cfg_gap,
  output logic            busy,
  output logic [31:0]     pkt_sent,
  output logic [DW-1:0]   AXIS_TDATA,
  output logic [DW/8-1:0] AXIS_TKEEP,
  output logic            AXIS_TLAST,
  output logic            AXIS_TVALID,
  input  logic            AXIS_TREADY
);

  state_t      state, state_next;
  logic [31:0] pkts_cfg;
  logic [15:0] beats_cfg;
  logic [7:0]  gap_cfg;
  logic [15:0] beat_cnt;
  logic [7:0]  gap_cnt;
  logic        abort_pend;
  logic        accept, handshake, last_beat, run_done;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handshake  = (state == SEND) && AXIS_TREADY;
    last_beat  = (beat_cnt == beats_cfg - 16'd1);
    run_done   = (pkt_sent + 32'd1 == pkts_cfg) || abort_pend || abort;
    case (state)
      IDLE: begin
        // busy stays high for one IDLE cycle after a run, so it also gates start
        if (start && !busy && cfg_packets != 32'd0 && cfg_beats != 16'd0) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake && last_beat) begin
          if (run_done)             state_next = IDLE;
          else if (gap_cfg != 8'd0) state_next = GAP;
          else                      state_next = SEND;
        end
      end
      GAP: begin
        if (abort)                             state_next = IDLE;
        else if (gap_cnt == gap_cfg - 8'd1)    state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy       <= 1'b0;
      pkt_sent   <= 32'd0;
      pkts_cfg   <= 32'd0;
      beats_cfg  <= 16'd0;
      gap_cfg    <= 8'd0;
      beat_cnt   <= 16'd0;
      gap_cnt    <= 8'd0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= accept;
          if (accept) begin
            pkts_cfg  <= cfg_packets;
            beats_cfg <= cfg_beats;
            gap_cfg   <= cfg_gap;
            pkt_sent  <= 32'd0;
            beat_cnt  <= 16'd0;
            gap_cnt   <= 8'd0;
          end
        end
        SEND: begin
          if (handshake) begin
            if (last_beat) begin
              beat_cnt <= 16'd0;
              pkt_sent <= pkt_sent + 32'd1;
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        GAP: gap_cnt <= (state_next == GAP) ? gap_cnt + 8'd1 : 8'd0;
        default: ;
      endcase
      // An abort in SEND waits for the packet's TLAST; leaving the run clears it
      if (state_next == IDLE)             abort_pend <= 1'b0;
      else if (state == SEND && abort)    abort_pend <= 1'b1;
    end
  end

  assign AXIS_TVALID = (state == SEND);
  assign AXIS_TLAST  = (state == SEND) && last_beat;
  assign AXIS_TKEEP  = '1;
  assign AXIS_TDATA  = {(DW/WORD_W){pattern_word(pkt_sent[IDX_W-1:0], beat_cnt)}};

endmodule

// File: tb/tb_pkt_gen.sv
// Scoreboard bench for pkt_gen: runs push expected beats from a packet-level
// model, and an independent monitor pops and compares each handshaken beat.
module tb_pkt_gen;

  localparam int DW    = 128;
  localparam int WORDS = DW / 32;
  localparam logic [DW/8-1:0] KEEP_ALL = '1;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic            abort;
  logic [31:0]     cfg_packets;
  logic [15:0]     cfg_beats;
  logic [7:0]      cfg_gap;
  logic            busy;
  logic [31:0]     pkt_sent;
  logic [DW-1:0]   AXIS_TDATA;
  logic [DW/8-1:0] AXIS_TKEEP;
  logic            AXIS_TLAST;
  logic            AXIS_TVALID;
  logic            AXIS_TREADY;

  typedef struct packed {
    logic [31:0] word;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    compared   = 0;
  int    mismatched = 0;
  bit    rand_ready = 1'b0;
  int    run_busy, run_beats, run_lasts, run_max_gap, run_first_valid;

  pkt_gen #(.DW(DW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_packets(cfg_packets), .cfg_beats(cfg_beats), .cfg_gap(cfg_gap),
    .busy(busy), .pkt_sent(pkt_sent),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TKEEP(AXIS_TKEEP), .AXIS_TLAST(AXIS_TLAST),
    .AXIS_TVALID(AXIS_TVALID), .AXIS_TREADY(AXIS_TREADY)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkData(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a run of p packets of b beats is the word sequence
  // {packet,beat} in order, with last set on the final beat of each packet.
  task automatic pushModel(input int p, input int b);
    beat_t e;
    for (int pi = 0; pi < p; pi++) begin
      for (int bi = 0; bi < b; bi++) begin
        e.word = {pi[15:0], bi[15:0]};
        e.last = (bi == b - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Pulse start with the given config, then scramble cfg to show it was latched.
  task automatic applyStimulus(input int p, input int b, input int g, input int model_pkts, input bit with_abort);
    cfg_packets = p;
    cfg_beats   = b[15:0];
    cfg_gap     = g[7:0];
    start       = 1'b1;
    abort       = with_abort;
    pushModel(model_pkts, b);
    tick();
    start       = 1'b0;
    abort       = 1'b0;
    cfg_packets = $urandom;
    cfg_beats   = 16'($urandom);
    cfg_gap     = 8'($urandom);
  endtask

  // Follows a run at falling edges until busy drops, measuring it and
  // optionally injecting abort, a stray start or a reset at a given beat.
  task automatic runMonitor(input int abort_at, input int restart_at, input int reset_at);
    int cur;
    bit seen_last, finished, set_abort, set_start, did_abort, did_start;
    run_busy = 0; run_beats = 0; run_lasts = 0; run_max_gap = 0; run_first_valid = 0;
    cur = 0; seen_last = 0; finished = 0; did_abort = 0; did_start = 0;
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      @(negedge clk);
      set_abort = 1'b0;
      set_start = 1'b0;
      if (!busy) begin
        finished = 1;
      end else begin
        run_busy++;
        if (AXIS_TVALID) begin
          if (run_first_valid == 0) run_first_valid = run_busy;
          if (seen_last && cur > run_max_gap) run_max_gap = cur;
          cur = 0;
        end else if (seen_last) begin
          cur++;
        end
        if (reset_at >= 0 && AXIS_TVALID && run_beats == reset_at) begin
          #1 resetn = 1'b0;
          finished = 1;
        end else begin
          if (abort_at >= 0 && !did_abort && AXIS_TVALID && run_beats == abort_at) begin
            set_abort = 1'b1;
            did_abort = 1;
          end
          if (restart_at >= 0 && !did_start && AXIS_TVALID && run_beats == restart_at) begin
            set_start = 1'b1;
            did_start = 1;
          end
          if (AXIS_TVALID && AXIS_TREADY) begin
            run_beats++;
            if (AXIS_TLAST) begin
              run_lasts++;
              seen_last = 1;
            end
          end
          #1;
          abort = set_abort;
          start = set_start;
          if (set_start) begin
            cfg_packets = 32'd7;
            cfg_beats   = 16'd9;
            cfg_gap     = 8'd0;
          end
        end
      end
    end
    abort = 1'b0;
    start = 1'b0;
    if (!finished) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL run_timeout: busy still %0d after 5000 cycles, expected 0", busy);
    end
  endtask

  initial begin
    AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      AXIS_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold under stall.
  initial begin
    beat_t         exp;
    bit            stalled;
    logic [DW-1:0] held_data;
    logic          held_last;
    stalled = 0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          checkOutput("stall_valid", 32'(AXIS_TVALID), 32'd1);
          checkData("stall_data", AXIS_TDATA, held_data);
          checkOutput("stall_last", 32'(AXIS_TLAST), 32'(held_last));
        end
        if (AXIS_TVALID && AXIS_TREADY) begin
          checkOutput("tkeep", 32'(AXIS_TKEEP), 32'(KEEP_ALL));
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_beat: got data %h, expected no beat", AXIS_TDATA);
          end else begin
            exp = sb.pop_front();
            checkData("tdata", AXIS_TDATA, {WORDS{exp.word}});
            checkOutput("tlast", 32'(AXIS_TLAST), 32'(exp.last));
          end
        end
        stalled   = AXIS_TVALID && !AXIS_TREADY;
        held_data = AXIS_TDATA;
        held_last = AXIS_TLAST;
      end
    end
  end

  initial begin
    int g;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_packets = '0; cfg_beats = '0; cfg_gap = '0;
    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tvalid", 32'(AXIS_TVALID), 32'd0);
    checkOutput("rst_tlast", 32'(AXIS_TLAST), 32'd0);
    checkOutput("rst_pkt_sent", pkt_sent, 32'd0);
    resetn = 1'b1;
    tick();

    // Back-to-back packets with no gap
    applyStimulus(3, 4, 0, 3, 0);
    runMonitor(-1, -1, -1);
    checkOutput("A_busy_cycles", run_busy, 3 * 4 + 1);
    checkOutput("A_beats", run_beats, 12);
    checkOutput("A_lasts", run_lasts, 3);
    checkOutput("A_first_valid", run_first_valid, 1);
    checkOutput("A_gap", run_max_gap, 0);
    checkOutput("A_pkt_sent", pkt_sent, 32'd3);
    checkOutput("A_sb_empty", sb.size(), 0);

    // Idle gap between packets
    applyStimulus(2, 2, 5, 2, 0);
    runMonitor(-1, -1, -1);
    checkOutput("B_busy_cycles", run_busy, 2 * 2 + 5 + 1);
    checkOutput("B_gap", run_max_gap, 5);
    checkOutput("B_beats", run_beats, 4);
    checkOutput("B_pkt_sent", pkt_sent, 32'd2);

    // Random backpressure
    rand_ready = 1'b1;
    g = $urandom_range(0, 3);
    applyStimulus(4, 8, g, 4, 0);
    runMonitor(-1, -1, -1);
    rand_ready = 1'b0;
    tick();
    checkOutput("C_beats", run_beats, 32);
    checkOutput("C_lasts", run_lasts, 4);
    checkOutput("C_gap", run_max_gap, g);
    checkOutput("C_pkt_sent", pkt_sent, 32'd4);
    checkOutput("C_sb_empty", sb.size(), 0);

    // Abort at beat 2 of packet 0 lets that packet finish
    applyStimulus(3, 6, 0, 1, 0);
    runMonitor(2, -1, -1);
    checkOutput("D_busy_cycles", run_busy, 6 + 1);
    checkOutput("D_beats", run_beats, 6);
    checkOutput("D_lasts", run_lasts, 1);
    checkOutput("D_pkt_sent", pkt_sent, 32'd1);
    checkOutput("D_sb_empty", sb.size(), 0);

    // Zero-sized starts are ignored and pkt_sent holds
    applyStimulus(0, 5, 0, 0, 0);
    repeat (4) tick();
    checkOutput("E_zero_pkts_busy", 32'(busy), 32'd0);
    checkOutput("E_zero_pkts_hold", pkt_sent, 32'd1);
    applyStimulus(2, 0, 0, 0, 0);
    repeat (4) tick();
    checkOutput("E_zero_beats_busy", 32'(busy), 32'd0);
    checkOutput("E_zero_beats_valid", 32'(AXIS_TVALID), 32'd0);
    checkOutput("E_zero_beats_hold", pkt_sent, 32'd1);

    // A start while busy does not disturb the run
    applyStimulus(2, 3, 1, 2, 0);
    runMonitor(-1, 1, -1);
    checkOutput("E_busy_cycles", run_busy, 2 * 3 + 1 + 1);
    checkOutput("E_beats", run_beats, 6);
    checkOutput("E_pkt_sent", pkt_sent, 32'd2);
    repeat (3) tick();
    checkOutput("E_idle_after", 32'(busy), 32'd0);

    // Start and abort together in IDLE: start wins
    applyStimulus(1, 2, 0, 1, 1);
    runMonitor(-1, -1, -1);
    checkOutput("F_busy_cycles", run_busy, 3);
    checkOutput("F_beats", run_beats, 2);
    checkOutput("F_pkt_sent", pkt_sent, 32'd1);

    // Reset mid-packet abandons it; a fresh run then works
    applyStimulus(2, 8, 0, 2, 0);
    runMonitor(-1, -1, 3);
    tick();
    checkOutput("G_rst_tvalid", 32'(AXIS_TVALID), 32'd0);
    checkOutput("G_rst_busy", 32'(busy), 32'd0);
    checkOutput("G_rst_pkt_sent", pkt_sent, 32'd0);
    sb.delete();
    tick();
    resetn = 1'b1;
    tick();
    applyStimulus(1, 3, 2, 1, 0);
    runMonitor(-1, -1, -1);
    checkOutput("G_beats", run_beats, 3);
    checkOutput("G_busy_cycles", run_busy, 4);
    checkOutput("G_pkt_sent", pkt_sent, 32'd1);
    checkOutput("G_sb_empty", sb.size(), 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
